rf_operand_stage: RTL and testbench
===================================

// Module: rf_operand_stage
// PURPOSE
//  Operand-fetch stage directly upstream of the register file, sitting between decode and execute.
//  Drives rs1/rs2 read addresses to reg_file and registers operands into the ID/EX pipeline register.
//  Tracks in-flight destination registers in a 32-bit pending-write scoreboard and stalls decode on RAW/WAW hazards.
//  Uses valid/ready handshakes on both sides.
// PARAMETERS
//  XLEN      32  data width; must match word_t
//  NUM_REGS  32  architectural registers; address width = $clog2(NUM_REGS), matches rf_addr_t
// PORTS
//  clk            in   1     clock; all state updates on posedge
//  rst_n          in   1     synchronous active-low reset
//  in_valid       in   1     decode presents an instruction
//  in_ready       out  1     stage accepts the instruction this cycle
//  in_rs1         in   5     source register 1
//  in_rs2         in   5     source register 2
//  in_rd          in   5     destination register
//  in_rd_wen      in   1     instruction writes in_rd
//  in_pc          in   32    instruction PC, passed through unchanged
//  rf_rd_reg_1    out  5     to reg_file rd_reg_1; combinational copy of in_rs1
//  rf_rd_reg_2    out  5     to reg_file rd_reg_2; combinational copy of in_rs2
//  rf_rd_data_1   in   32    from reg_file; asynchronous read
//  rf_rd_data_2   in   32    from reg_file; asynchronous read
//  wb_wr_en       in   1     writeback write strobe, the same signal that drives reg_file wr_en
//  wb_wr_reg      in   5     writeback destination register
//  wb_wr_data     in   32    writeback data
//  out_valid      out  1     ID/EX register holds a valid instruction
//  out_ready      in   1     execute consumes the instruction
//  out_rs1_data   out  32    registered operand 1
//  out_rs2_data   out  32    registered operand 2
//  out_rd         out  5     registered in_rd
//  out_rd_wen     out  1     registered in_rd_wen
//  out_pc         out  32    registered in_pc
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - out_valid=0; out_* data=0; scoreboard pending[31:0]=0.
//   - in_ready evaluates 0 while rst_n=0.
//  Scoreboard clear mask
//   - clr = onehot(wb_wr_reg) when wb_wr_en && wb_wr_reg!=0, else 0.
//  Scoreboard hazard check
//   - eff = pending & ~clr (macro on); eff = pending (macro off).
//   - hazard = eff[in_rs1] | eff[in_rs2] | (in_rd_wen & eff[in_rd]).
//   - Register x0 is never pending and never hazards.
//  Handshake
//   - in_ready = rst_n & (!out_valid | out_ready) & !hazard.
//   - Accept when in_valid && in_ready.
//   - in_ready does not depend on in_valid; in_rs* may still feed the hazard term.
//  Pipeline register update
//   - On accept, capture operands/rd/rd_wen/pc and set out_valid=1 at the next edge (latency 1 cycle).
//   - Else if out_ready, clear out_valid.
//   - Else hold all out_* stable while out_valid && !out_ready.
//  Operand selection
//   - rsN==0 -> 0.
//   - Else bypass hit -> wb_wr_data.
//   - Else rf_rd_data_N.
//  Scoreboard update
//   - pending_next = (pending & ~clr) | set.
//   - set = onehot(in_rd) on accept with in_rd_wen && in_rd!=0.
//   - Set wins when set and clr hit the same register in the same cycle.
//  Boundary conditions
//   - Write to an already-clear register: no effect.
//   - rs1==rs2: both operands are bypassed identically.
//   - Reset mid-stall: drops the held instruction and all pending bits.
//  No internal FSM beyond out_valid and the scoreboard; execute/writeback guarantee one write per set bit.
// CONFIGURATION
//  RF_BYPASS_EN defined
//   - A register whose writeback occurs this cycle is not a hazard.
//   - Its operand is taken from wb_wr_data, because reg_file returns old data during a same-cycle write.
//  RF_BYPASS_EN undefined
//   - No bypass mux; hazard uses the full pending vector.
//   - The dependent instruction stalls one extra cycle and reads the committed value from reg_file.
// TESTING
//  - Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, in_ready=0, pending=0.
//  - Basic issue: rs1=3 (rf=0x11), rs2=4 (rf=0x22), rd=5 -> next cycle out_valid=1, out_rs1_data=0x11, out_rs2_data=0x22, pending[5]=1.
//  - RAW stall: after the above, issue rs1=5 -> in_ready=0 until wb_wr_en=1, wb_wr_reg=5, wb_wr_data=0xCAFE.
//    - Bypass on: accepted that cycle, out_rs1_data=0xCAFE.
//    - Bypass off: accepted one cycle later with rf value 0xCAFE.
//  - x0: rd=0, rd_wen=1, then rs1=0 -> no pending bit, no stall, out_rs1_data=0 even if rf returns 0xFFFFFFFF.
//  - Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* held; out_ready=1 -> next instruction issues.
//  - Set/clear same register: wb clears r7 while an issuing instruction sets r7 (bypass on) -> pending[7]=1 afterwards.

Source files
------------

// File: rtl/rf_operand_stage.sv
// rf_operand_stage: operand fetch ahead of execute with a pending-write scoreboard and ID/EX register.
// Optional macro RF_BYPASS_EN forwards same-cycle writeback data instead of stalling one extra cycle.
module rf_operand_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_wen,
  input  logic [31:0]     in_pc,
  output logic [AW-1:0]   rf_rd_reg_1,
  output logic [AW-1:0]   rf_rd_reg_2,
  input  logic [XLEN-1:0] rf_rd_data_1,
  input  logic [XLEN-1:0] rf_rd_data_2,
  input  logic            wb_wr_en,
  input  logic [AW-1:0]   wb_wr_reg,
  input  logic [XLEN-1:0] wb_wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wen,
  output logic [31:0]     out_pc
);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] clr_s;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] eff_s;
  logic                hazard_s;
  logic                accept_s;
  logic [XLEN-1:0]     op1_s;
  logic [XLEN-1:0]     op2_s;

  // x0 is hardwired, so it never enters the scoreboard
  function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [AW-1:0] r, input logic en);
    logic [NUM_REGS-1:0] v;
    v = {NUM_REGS{1'b0}};
    if (en && (r != {AW{1'b0}})) begin
      v[r] = 1'b1;
    end
    return v;
  endfunction

  assign rf_rd_reg_1 = in_rs1;
  assign rf_rd_reg_2 = in_rs2;

  // Scoreboard masks, hazard detection and input handshake
  always_comb begin
    clr_s = onehot_reg(wb_wr_reg, wb_wr_en);
`ifdef RF_BYPASS_EN
    eff_s = pending_r & ~clr_s;
`else
    eff_s = pending_r;
`endif
    hazard_s = eff_s[in_rs1] | eff_s[in_rs2] | (in_rd_wen & eff_s[in_rd]);
    in_ready = rst_n & (~out_valid | out_ready) & ~hazard_s;
    accept_s = in_valid & in_ready;
    set_s    = onehot_reg(in_rd, accept_s & in_rd_wen);
  end

  // Operand select: x0 reads zero, a same-cycle writeback may forward, else the register file
  always_comb begin
    if (in_rs1 == {AW{1'b0}}) begin
      op1_s = {XLEN{1'b0}};
    end
`ifdef RF_BYPASS_EN
    else if (wb_wr_en && (wb_wr_reg == in_rs1)) begin
      op1_s = wb_wr_data;
    end
`endif
    else begin
      op1_s = rf_rd_data_1;
    end
    if (in_rs2 == {AW{1'b0}}) begin
      op2_s = {XLEN{1'b0}};
    end
`ifdef RF_BYPASS_EN
    else if (wb_wr_en && (wb_wr_reg == in_rs2)) begin
      op2_s = wb_wr_data;
    end
`endif
    else begin
      op2_s = rf_rd_data_2;
    end
  end

`ifndef RF_BYPASS_EN
  logic unused_wb_data_s;
  assign unused_wb_data_s = ^wb_wr_data;
`endif

  // ID/EX pipeline register and scoreboard; a set in the same cycle as a clear keeps the bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r    <= {NUM_REGS{1'b0}};
      out_valid    <= 1'b0;
      out_rs1_data <= {XLEN{1'b0}};
      out_rs2_data <= {XLEN{1'b0}};
      out_rd       <= {AW{1'b0}};
      out_rd_wen   <= 1'b0;
      out_pc       <= 32'd0;
    end else begin
      pending_r <= (pending_r & ~clr_s) | set_s;
      if (accept_s) begin
        out_valid    <= 1'b1;
        out_rs1_data <= op1_s;
        out_rs2_data <= op2_s;
        out_rd       <= in_rd;
        out_rd_wen   <= in_rd_wen;
        out_pc       <= in_pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_rf_operand_stage.sv
// Randomized bench for rf_operand_stage against a set-of-busy-registers model with a behavioural register file.
module tb_rf_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_rd_wen, wb_wr_en, out_valid, out_ready, out_rd_wen;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_rd_reg_1, rf_rd_reg_2, wb_wr_reg, out_rd;
  logic [31:0] in_pc, rf_rd_data_1, rf_rd_data_2, wb_wr_data, out_rs1_data, out_rs2_data, out_pc;

  logic [31:0] rf_mem [32];
  bit          pend [32];
  logic        m_valid, m_wen, seen_ready;
  logic [31:0] m_op1, m_op2, m_pc;
  logic [4:0]  m_rd;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  assign rf_rd_data_1 = rf_mem[rf_rd_reg_1];
  assign rf_rd_data_2 = rf_mem[rf_rd_reg_2];

  rf_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_pc(in_pc),
    .rf_rd_reg_1(rf_rd_reg_1), .rf_rd_reg_2(rf_rd_reg_2),
    .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_pc(out_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A register blocks issue while it awaits writeback, unless that writeback lands now and forwarding exists
  function automatic bit busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (wb_wr_en && (wb_wr_reg == r)) return 1'b0;
`endif
    return pend[r];
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wb_wr_en && (wb_wr_reg == r)) return wb_wr_data;
`endif
    return rf_mem[r];
  endfunction

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen; in_pc = $urandom;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_wr_en = en; wb_wr_reg = r; wb_wr_data = d;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    logic        exp_ready;
    logic [31:0] op1, op2;
    #1;
    exp_ready = rst_n && (!m_valid || out_ready) && !(busy(in_rs1) || busy(in_rs2) || (in_rd_wen && busy(in_rd)));
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("rf_rd_reg_1", 32'(rf_rd_reg_1), 32'(in_rs1));
    check_eq("rf_rd_reg_2", 32'(rf_rd_reg_2), 32'(in_rs2));
    seen_ready = in_ready;
    op1 = m_operand(in_rs1);
    op2 = m_operand(in_rs2);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      foreach (pend[i]) pend[i] = 1'b0;
      m_valid = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_rd = 5'd0; m_wen = 1'b0; m_pc = 32'd0;
    end else begin
      if (wb_wr_en && wb_wr_reg != 5'd0) pend[wb_wr_reg] = 1'b0;
      if (in_valid && exp_ready) begin
        if (in_rd_wen && in_rd != 5'd0) pend[in_rd] = 1'b1;
        m_valid = 1'b1; m_op1 = op1; m_op2 = op2; m_rd = in_rd; m_wen = in_rd_wen; m_pc = in_pc;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    if (wb_wr_en && wb_wr_reg != 5'd0) rf_mem[wb_wr_reg] = wb_wr_data;
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_rs1_data", out_rs1_data, m_op1);
    check_eq("out_rs2_data", out_rs2_data, m_op2);
    check_eq("out_rd", 32'(out_rd), 32'(m_rd));
    check_eq("out_rd_wen", 32'(out_rd_wen), 32'(m_wen));
    check_eq("out_pc", out_pc, m_pc);
  endtask

  initial begin
    int plist[$];
    int r;
    foreach (rf_mem[i]) rf_mem[i] = $urandom;
    foreach (pend[i]) pend[i] = 1'b0;
    rf_mem[0] = 32'hFFFF_FFFF;
    rf_mem[3] = 32'h11;
    rf_mem[4] = 32'h22;
    m_valid = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_rd = 5'd0; m_wen = 1'b0; m_pc = 32'd0;

    // Reset held two cycles with a valid instruction presented
    rst_n = 1'b0; out_ready = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
    cycle(); cycle();
    check_eq("reset_ready", 32'(seen_ready), 32'd0);
    check_eq("reset_valid", 32'(out_valid), 32'd0);

    // Basic issue
    rst_n = 1'b1;
    cycle();
    check_eq("basic_rs1", out_rs1_data, 32'h11);
    check_eq("basic_rs2", out_rs2_data, 32'h22);

    // RAW on r5, resolved by writeback of 0xCAFE
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
    cycle();
    check_eq("raw_stall", 32'(seen_ready), 32'd0);
    set_wb(1'b1, 5'd5, 32'hCAFE);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
`ifndef RF_BYPASS_EN
    check_eq("raw_extra_stall", 32'(seen_ready), 32'd0);
    cycle();
`endif
    check_eq("raw_operand", out_rs1_data, 32'hCAFE);

    // x0 never becomes pending and always reads zero
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    set_in(1'b1, 5'd0, 5'd0, 5'd1, 1'b0);
    cycle();
    check_eq("x0_ready", 32'(seen_ready), 32'd1);
    check_eq("x0_operand", out_rs1_data, 32'd0);

    // Backpressure: hold r8 instruction for three cycles, then issue the next one
    set_in(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
    cycle();
    out_ready = 1'b0;
    set_in(1'b1, 5'd3, 5'd3, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("bp_ready", 32'(seen_ready), 32'd0);
    check_eq("bp_hold_rd", 32'(out_rd), 32'd8);
    out_ready = 1'b1;
    cycle();
    check_eq("bp_release_rd", 32'(out_rd), 32'd9);
    check_eq("same_rs_bypass", out_rs1_data, out_rs2_data);

    // Same-cycle clear and set of r7
    set_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    cycle();
    set_wb(1'b1, 5'd7, 32'h77);
    cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd7, 5'd0, 5'd10, 1'b0);
    cycle();
`ifdef RF_BYPASS_EN
    check_eq("setclr_pending", 32'(seen_ready), 32'd0);
`endif

    // Reset during a stall drops everything pending
    out_ready = 1'b0;
    set_in(1'b1, 5'd8, 5'd9, 5'd11, 1'b1);
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; out_ready = 1'b1;
    cycle();
    check_eq("post_reset_ready", 32'(seen_ready), 32'd1);

    // Randomized traffic with writebacks drawn from the busy set
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      set_in($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      plist.delete();
      foreach (pend[i]) if (pend[i]) plist.push_back(i);
      if (plist.size() > 0 && $urandom_range(0, 9) < 4) begin
        set_wb(1'b1, 5'(plist[$urandom_range(0, plist.size() - 1)]), $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 31);
        set_wb(!pend[r], 5'(r), $urandom);
      end else begin
        set_wb(1'b0, 5'd0, 32'd0);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
